// File: rtl/preg_pkg.sv
// -----------------------------------------------------------------------------
// preg_pkg
// Shared constants for the physical register file and its scoreboard:
//   - default data width and register address width
//   - stack pointer and heap pointer reset values
//   - indices of the special registers (zero, stack pointer, heap pointer)
//   - init_value(): reset value of any register index
// -----------------------------------------------------------------------------
package preg_pkg;

    localparam int DEF_LEN    = 32;
    localparam int DEF_ADDR_W = 6;

    // Address width of the data memory; the stack starts 4 words-of-that-size up.
    localparam int MEM_DATA_ADDR_W = 12;

    localparam logic [31:0] SP_INIT = 32'(32'h4 << MEM_DATA_ADDR_W);
    localparam logic [31:0] HP_INIT = 32'h0000_1000;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 2;
    localparam int REG_HP   = 3;

    // Reset value of register idx; everything except SP and HP starts at zero.
    function automatic logic [31:0] init_value(input int idx);
        logic [31:0] val;
        val = '0;
        if (idx == REG_SP) val = SP_INIT;
        if (idx == REG_HP) val = HP_INIT;
        return val;
    endfunction

endpackage

// File: rtl/preg_file_scoreboard.sv
// -----------------------------------------------------------------------------
// preg_scoreboard
// Busy bit per physical register plus a registered count of busy registers.
// Priority at each edge, lowest to highest:
//   writes clear busy  <  alloc sets busy  <  flush clears everything
//   and the synchronous reset overrides all of them.
// Register 0 is never marked busy.
//
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   alloc_en    reserve alloc_addr (mark busy)
//   alloc_addr  register to reserve
//   wr_en       per-write-port strobe
//   wr_addr     packed write addresses, port j in [j*ADDR_W +: ADDR_W]
//   flush       clear all busy bits
//   busy        current busy vector, one bit per register
//   n_busy      registered popcount of busy
// -----------------------------------------------------------------------------
module preg_scoreboard
    import preg_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N_WR   = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   alloc_en,
    input  logic [ADDR_W-1:0]      alloc_addr,
    input  logic [N_WR-1:0]        wr_en,
    input  logic [N_WR*ADDR_W-1:0] wr_addr,
    input  logic                   flush,
    output logic [2**ADDR_W-1:0]   busy,
    output logic [ADDR_W:0]        n_busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  n_busy_q, n_busy_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        busy_d = busy_q;

        for (int j = 0; j < N_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                busy_d[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end

        // A new producer outranks a writeback to the same register.
        if (alloc_en && (alloc_addr != '0)) begin
            busy_d[alloc_addr] = 1'b1;
        end

        // Squash wins over everything, including a same-cycle alloc.
        if (flush) begin
            busy_d = '0;
        end

        n_busy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n_busy_d = n_busy_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q   <= '0;
            n_busy_q <= '0;
        end else begin
            busy_q   <= busy_d;
            n_busy_q <= n_busy_d;
        end
    end

    assign busy   = busy_q;
    assign n_busy = n_busy_q;

endmodule

// File: rtl/preg_file.sv
// -----------------------------------------------------------------------------
// preg_file
// Multi-read / multi-write physical register file with a busy scoreboard so
// issue can stall on operands whose producer has not written back yet.
//
// Optional feature macro: PREG_BYPASS_EN
//   defined   - reads forward same-cycle write data (highest write port wins)
//               and report ready on a match unless a same-cycle alloc hits
//               the same register.
//   undefined - reads reflect stored state only.
//
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   rd_addr     packed read addresses, port k in [k*ADDR_W +: ADDR_W]
//   rd_data     packed combinational read data, port k in [k*LEN +: LEN]
//   rd_ready    per read port: 1 = operand valid (register not busy)
//   alloc_en    reserve alloc_addr as a pending destination
//   alloc_addr  register to reserve
//   wr_en       per-write-port strobe
//   wr_addr     packed write addresses
//   wr_data     packed write data
//   flush       clear all busy bits; contents untouched
//   n_busy      registered count of busy registers
// -----------------------------------------------------------------------------
module preg_file
    import preg_pkg::*;
#(
    parameter int LEN    = DEF_LEN,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N_RD   = 3,
    parameter int N_WR   = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [N_RD*LEN-1:0]    rd_data,
    output logic [N_RD-1:0]        rd_ready,
    input  logic                   alloc_en,
    input  logic [ADDR_W-1:0]      alloc_addr,
    input  logic [N_WR-1:0]        wr_en,
    input  logic [N_WR*ADDR_W-1:0] wr_addr,
    input  logic [N_WR*LEN-1:0]    wr_data,
    input  logic                   flush,
    output logic [ADDR_W:0]        n_busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [LEN-1:0]   mem_q [DEPTH];
    logic [LEN-1:0]   mem_d [DEPTH];
    logic [DEPTH-1:0] busy;

    preg_scoreboard #(
        .ADDR_W (ADDR_W),
        .N_WR   (N_WR)
    ) u_scoreboard (
        .clk        (clk),
        .rstn       (rstn),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .flush      (flush),
        .busy       (busy),
        .n_busy     (n_busy)
    );

    // Ports are applied in ascending order so the highest-indexed port wins
    // on an address collision. Address 0 is never written.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < N_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                mem_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*LEN +: LEN];
            end
        end
    end

    // NOTE: the array is reset because SP and HP have architectural start
    // values; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= LEN'(init_value(i));
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Register 0 is never written and never busy, so it reads 0 / ready.
    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        for (int k = 0; k < N_RD; k++) begin
            rd_data[k*LEN +: LEN] = mem_q[rd_addr[k*ADDR_W +: ADDR_W]];
            rd_ready[k]           = ~busy[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef PREG_BYPASS_EN
            for (int j = 0; j < N_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0) &&
                    (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W])) begin
                    rd_data[k*LEN +: LEN] = wr_data[j*LEN +: LEN];
                    // A same-cycle alloc means a newer producer is in flight.
                    if (!(alloc_en && (alloc_addr == rd_addr[k*ADDR_W +: ADDR_W]))) begin
                        rd_ready[k] = 1'b1;
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_preg_file.sv
// -----------------------------------------------------------------------------
// tb_preg_file
// Directed self-checking bench for preg_file (LEN=32, ADDR_W=6, N_RD=3,
// N_WR=2). Expectations follow PREG_BYPASS_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_preg_file;

    localparam int LEN    = 32;
    localparam int ADDR_W = 6;
    localparam int N_RD   = 3;
    localparam int N_WR   = 2;

    localparam logic [31:0] EXP_SP = 32'h0000_4000;
    localparam logic [31:0] EXP_HP = 32'h0000_1000;

    logic                   clk;
    logic                   rstn;
    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD*LEN-1:0]    rd_data;
    logic [N_RD-1:0]        rd_ready;
    logic                   alloc_en;
    logic [ADDR_W-1:0]      alloc_addr;
    logic [N_WR-1:0]        wr_en;
    logic [N_WR*ADDR_W-1:0] wr_addr;
    logic [N_WR*LEN-1:0]    wr_data;
    logic                   flush;
    logic [ADDR_W:0]        n_busy;

    int n_checks = 0;
    int n_errors = 0;

    preg_file #(
        .LEN    (LEN),
        .ADDR_W (ADDR_W),
        .N_RD   (N_RD),
        .N_WR   (N_WR)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .flush      (flush),
        .n_busy     (n_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
        rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic set_wr(input int j, input logic [ADDR_W-1:0] a, input logic [LEN-1:0] d);
        wr_en[j]                    = 1'b1;
        wr_addr[j*ADDR_W +: ADDR_W] = a;
        wr_data[j*LEN +: LEN]       = d;
    endtask

    task automatic idle();
        wr_en    = '0;
        alloc_en = 1'b0;
        flush    = 1'b0;
    endtask

    function automatic logic [31:0] rd(input int k);
        return rd_data[k*LEN +: LEN];
    endfunction

    initial begin
        rstn       = 1'b0;
        rd_addr    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        flush      = 1'b0;

        // ---- reset ----
        step();
        step();
        rstn = 1'b1;
        step();
        set_rd(0, 6'd1);
        set_rd(1, 6'd2);
        set_rd(2, 6'd3);
        settle();
        check("reset_reg1", rd(0), 32'h0);
        check("reset_sp", rd(1), EXP_SP);
        check("reset_hp", rd(2), EXP_HP);
        check("reset_ready", 32'(rd_ready), 32'h7);
        check("reset_nbusy", 32'(n_busy), 32'h0);

        // ---- writes to register 0 are dropped ----
        set_rd(0, 6'd0);
        set_wr(0, 6'd0, 32'hDEAD_BEEF);
        set_wr(1, 6'd0, 32'hDEAD_BEEF);
        settle();
        check("reg0_same_cycle", rd(0), 32'h0);
        step();
        idle();
        settle();
        check("reg0_after", rd(0), 32'h0);
        check("reg0_ready", 32'(rd_ready[0]), 32'h1);
        check("reg0_nbusy", 32'(n_busy), 32'h0);

        // ---- alloc reg 5, then port 1 writes it back ----
        alloc_en   = 1'b1;
        alloc_addr = 6'd5;
        step();
        idle();
        set_rd(0, 6'd5);
        settle();
        check("alloc5_ready", 32'(rd_ready[0]), 32'h0);
        check("alloc5_nbusy", 32'(n_busy), 32'h1);
        set_wr(1, 6'd5, 32'h0000_1234);
        settle();
`ifdef PREG_BYPASS_EN
        check("wb5_bypass_data", rd(0), 32'h0000_1234);
        check("wb5_bypass_ready", 32'(rd_ready[0]), 32'h1);
`else
        check("wb5_old_data", rd(0), 32'h0);
        check("wb5_old_ready", 32'(rd_ready[0]), 32'h0);
`endif
        step();
        idle();
        settle();
        check("wb5_data", rd(0), 32'h0000_1234);
        check("wb5_ready", 32'(rd_ready[0]), 32'h1);
        check("wb5_nbusy", 32'(n_busy), 32'h0);

        // ---- write-port collision on reg 7: port 1 wins ----
        set_rd(0, 6'd7);
        set_wr(0, 6'd7, 32'h0000_AAAA);
        set_wr(1, 6'd7, 32'h0000_5555);
        settle();
`ifdef PREG_BYPASS_EN
        check("coll7_bypass", rd(0), 32'h0000_5555);
`else
        check("coll7_old", rd(0), 32'h0);
`endif
        step();
        idle();
        settle();
        check("coll7_data", rd(0), 32'h0000_5555);

        // ---- alloc + write on reg 9: data stored, still busy ----
        alloc_en   = 1'b1;
        alloc_addr = 6'd9;
        set_wr(0, 6'd9, 32'h0000_0099);
        step();
        idle();
        set_rd(0, 6'd9);
        settle();
        check("aw9_data", rd(0), 32'h0000_0099);
        check("aw9_ready", 32'(rd_ready[0]), 32'h0);
        check("aw9_nbusy", 32'(n_busy), 32'h1);

        // ---- flush with a same-cycle alloc of reg 10 ----
        flush      = 1'b1;
        alloc_en   = 1'b1;
        alloc_addr = 6'd10;
        step();
        idle();
        set_rd(0, 6'd9);
        set_rd(1, 6'd10);
        set_rd(2, 6'd5);
        settle();
        check("flush_ready", 32'(rd_ready), 32'h7);
        check("flush_nbusy", 32'(n_busy), 32'h0);
        check("flush_keeps_data", rd(0), 32'h0000_0099);

        // ---- alloc 4..8 (reg 4 also written), then a one-cycle reset ----
        for (int r = 4; r <= 8; r++) begin
            alloc_en   = 1'b1;
            alloc_addr = 6'(r);
            if (r == 4) set_wr(0, 6'd4, 32'h0000_0044);
            step();
            wr_en = '0;
        end
        idle();
        set_rd(0, 6'd4);
        set_rd(1, 6'd6);
        set_rd(2, 6'd8);
        settle();
        check("busy48_nbusy", 32'(n_busy), 32'h5);
        check("busy48_ready", 32'(rd_ready), 32'h0);
        check("busy48_reg4", rd(0), 32'h0000_0044);

        rstn       = 1'b0;
        alloc_en   = 1'b1;
        alloc_addr = 6'd11;
        step();
        rstn = 1'b1;
        idle();
        set_rd(1, 6'd11);
        set_rd(2, 6'd2);
        settle();
        check("rst_nbusy", 32'(n_busy), 32'h0);
        check("rst_ready", 32'(rd_ready), 32'h7);
        check("rst_reg4", rd(0), 32'h0);
        check("rst_sp", rd(2), EXP_SP);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/preg_file.md
# preg_file

Parametrised successor to the core's physical register file: a multi-read/multi-write register array with a per-register busy scoreboard, so the issue stage can stall on operands whose producer has not yet written back. It sits between decode/issue (reads, allocations) and the writeback stage(s) (writes), and replaces the single-write-port file in the core.

## Interface
- LEN, 32: data word width.
- ADDR_W, 6: register address width; depth = 2**ADDR_W.
- N_RD, 3: number of read ports.
- N_WR, 2: number of write ports.

Ports, clock and reset first:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- rd_addr  in  N_RD*ADDR_W  read addresses, port k in bits [k*ADDR_W +: ADDR_W].
- rd_data  out  N_RD*LEN  read data, combinational.
- rd_ready  out  N_RD  1 = register not busy (operand valid).
- alloc_en  in  1  reserve a destination register (mark busy).
- alloc_addr  in  ADDR_W  register to reserve.
- wr_en  in  N_WR  per-port write strobe.
- wr_addr  in  N_WR*ADDR_W  write addresses.
- wr_data  in  N_WR*LEN  write data.
- flush  in  1  clear all busy bits (pipeline squash); contents untouched.
- n_busy  out  ADDR_W+1  registered count of busy registers.

## Operation
- Register 0 reads as 0 and is always ready; writes and allocations to address 0 are ignored.
- On reset, all contents load their init values, all busy bits clear, and n_busy = 0:
  - reg 1 = 0.
  - reg 2 = stack pointer init.
  - reg 3 = heap pointer init.
  - All other registers = 0.
- Write: on each edge, every port with wr_en set and a nonzero address stores its data and clears that register's busy bit.
- Two write ports hitting the same address in one cycle: the highest-indexed port's data wins.
- Alloc: alloc_en with a nonzero address sets that register's busy bit.
- Alloc and write to the same address in the same cycle: busy ends set, because the new producer wins. The write data is still stored.
- flush clears every busy bit at the edge. Writes in the same cycle still store. An alloc in the same cycle is discarded, because flush dominates.
- n_busy is updated each edge as popcount of the next busy vector. It ranges 0 to 2**ADDR_W-1 and never wraps.
- rd_ready[k] = ~busy[rd_addr[k]], subject to the bypass rule under Configuration.
- Reset dominates all other inputs.

## Timing
- Reads are zero-latency combinational from rd_addr and the current state.
- Writes, allocations and flush take effect at the next rising edge of clk.
- Without bypass, a read in the cycle of a write returns the old value; the new value is visible one cycle later.
- Reset asserted mid-operation discards pending busy state at that edge. There is no drain.

## Configuration
- PREG_BYPASS_EN defined: read ports forward same-cycle write data when a write matches the read address and is nonzero.
  - Port priority is the same as for writes: the highest-indexed write port wins.
  - rd_ready[k] is forced to 1 on a match, unless alloc_en hits the same address in that cycle.
  - Result: writeback-to-issue latency is 0 cycles.
- PREG_BYPASS_EN undefined: rd_data and rd_ready reflect stored state only; writeback-to-issue latency is 1 cycle.

## Structure
- Shared package/include holds:
  - the stack pointer init constant (0x4 << memory-data address width);
  - the heap pointer init constant;
  - default LEN and ADDR_W;
  - the index constants of the special registers (ZERO=0, SP=2, HP=3).
- One sub-module, preg_scoreboard, holds the busy vector, the alloc/write/flush priority logic and the n_busy counter. The data array stays in preg_file.

## Test plan
- Reset, then read regs 1/2/3 -> 0 / SP init / heap init; all rd_ready = 1; n_busy = 0.
- Write 0xDEADBEEF to reg 0 via both ports -> reg 0 reads 0; n_busy unchanged.
- Alloc reg 5 -> next cycle rd_ready = 0 and n_busy = 1. Port 1 writes 0x1234 to reg 5 -> read 0x1234 with ready = 1 (same cycle with bypass, next cycle without); n_busy = 0.
- Ports 0 and 1 write 0xAAAA / 0x5555 to reg 7 in the same cycle -> reg 7 = 0x5555.
- Alloc reg 9 with a simultaneous write to reg 9 -> data stored, busy = 1. Then flush with alloc of reg 10 -> all ready; n_busy = 0.
- Alloc regs 4..8, then assert rstn = 0 for one cycle -> n_busy = 0, all ready, and reg 4 reads 0.
